// File: rtl/pace_horner_ctrl.sv
// Sequencer that evaluates one PACE piecewise polynomial per request with Horner's scheme.
// Segment select and the epsilon shortcut are local; every multiply-add goes to one shared external FMA.
module pace_horner_ctrl #(
    parameter int PaceDegree    = 2,
    parameter int PaceParts     = 16,
    parameter int PaceEps       = 1,
    parameter int PaceDataWidth = 32,
    parameter int TagWidth      = 4,
    localparam int NumCoef    = PaceParts * (PaceDegree + 1),
    localparam int NumBound   = PaceParts - 1,
    localparam int ParamWidth = (NumCoef + NumBound + 2 * PaceEps) * PaceDataWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ParamWidth-1:0]    pace_param_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [PaceDataWidth-1:0] in_x_i,
    input  logic [TagWidth-1:0]      in_tag_i,
    output logic                     fma_valid_o,
    input  logic                     fma_ready_i,
    output logic [PaceDataWidth-1:0] fma_a_o,
    output logic [PaceDataWidth-1:0] fma_b_o,
    output logic [PaceDataWidth-1:0] fma_c_o,
    input  logic                     fma_rsp_valid_i,
    output logic                     fma_rsp_ready_o,
    input  logic [PaceDataWidth-1:0] fma_rsp_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PaceDataWidth-1:0] out_y_o,
    output logic [TagWidth-1:0]      out_tag_o,
    output logic                     out_eps_o,
    output logic                     busy_o
);

    localparam int SegW       = (PaceParts > 1) ? $clog2(PaceParts) : 1;
    localparam int KW         = (PaceDegree > 0) ? $clog2(PaceDegree + 1) : 1;
    localparam int IdxW       = (NumCoef > 1) ? $clog2(NumCoef) : 1;
    localparam int BoundSlots = (NumBound > 0) ? NumBound : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Orderable key for FP32 sign-magnitude values; both zeros collapse onto +0.
    function automatic logic [31:0] fp_key(input logic [31:0] v);
        logic [31:0] z;
        z = (v[30:0] == 31'd0) ? 32'd0 : v;
        if (z[31]) begin
            fp_key = ~z;
        end else begin
            fp_key = z | 32'h8000_0000;
        end
    endfunction

    if (PaceDataWidth != 32) begin : g_width_check
        $error("pace_horner_ctrl: only PaceDataWidth=32 is supported");
    end

    logic [PaceDataWidth-1:0] coef_s  [NumCoef];
    logic [PaceDataWidth-1:0] bound_s [BoundSlots];
    logic [PaceDataWidth-1:0] eps_thr_s;
    logic [PaceDataWidth-1:0] eps_val_s;

    for (genvar i = 0; i < NumCoef; i++) begin : g_coef
        assign coef_s[i] = pace_param_i[i*PaceDataWidth +: PaceDataWidth];
    end

    if (NumBound > 0) begin : g_bounds
        for (genvar i = 0; i < NumBound; i++) begin : g_bound
            assign bound_s[i] = pace_param_i[(NumCoef+i)*PaceDataWidth +: PaceDataWidth];
        end
    end else begin : g_no_bounds
        assign bound_s[0] = '0;
    end

    if (PaceEps != 0) begin : g_eps
        assign eps_thr_s = pace_param_i[(NumCoef+NumBound)*PaceDataWidth +: PaceDataWidth];
        assign eps_val_s = pace_param_i[(NumCoef+NumBound+1)*PaceDataWidth +: PaceDataWidth];
    end else begin : g_no_eps
        assign eps_thr_s = '0;
        assign eps_val_s = '0;
    end

    state_e                   state_q;
    logic [PaceDataWidth-1:0] acc_q;
    logic [PaceDataWidth-1:0] x_q;
    logic [TagWidth-1:0]      tag_q;
    logic [SegW-1:0]          seg_q;
    logic [KW-1:0]            k_q;
    logic                     eps_q;
    logic                     in_ready_q;
    logic                     fma_valid_q;
    logic                     fma_rsp_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic [PaceDataWidth-1:0] fma_c_q;

    logic [SegW-1:0] seg_sel_s;
    logic            eps_hit_s;
    logic [IdxW-1:0] top_idx_s;
    logic [IdxW-1:0] first_idx_s;
    logic [IdxW-1:0] next_idx_s;
    logic            unused_eps_sign_s;

    // Segment index: number of bounds that x is at or above.
    always_comb begin
        seg_sel_s = '0;
        for (int b = 0; b < NumBound; b++) begin
            if (fp_key(x_q) >= fp_key(bound_s[b])) begin
                seg_sel_s = seg_sel_s + SegW'(1);
            end else begin
                seg_sel_s = seg_sel_s;
            end
        end
    end

    assign eps_hit_s         = (PaceEps != 0) && (x_q[30:0] < eps_thr_s[30:0]);
    assign unused_eps_sign_s = eps_thr_s[31];

    // Flat coefficient word indices for the leading term, the first issue and each later issue.
    always_comb begin
        top_idx_s   = IdxW'(seg_sel_s) * IdxW'(PaceDegree + 1) + IdxW'(PaceDegree);
        first_idx_s = top_idx_s - IdxW'(1);
        next_idx_s  = IdxW'(seg_q) * IdxW'(PaceDegree + 1) + IdxW'(k_q) - IdxW'(1);
    end

    // Request sequencer: state, datapath registers and all handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            acc_q           <= '0;
            x_q             <= '0;
            tag_q           <= '0;
            seg_q           <= '0;
            k_q             <= '0;
            eps_q           <= 1'b0;
            in_ready_q      <= 1'b1;
            fma_valid_q     <= 1'b0;
            fma_rsp_ready_q <= 1'b0;
            out_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            fma_c_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        x_q        <= in_x_i;
                        tag_q      <= in_tag_i;
                        eps_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    seg_q <= seg_sel_s;
                    if (eps_hit_s) begin
                        acc_q       <= eps_val_s;
                        eps_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        acc_q <= coef_s[top_idx_s];
                        k_q   <= KW'((PaceDegree > 0) ? PaceDegree - 1 : 0);
                        if (PaceDegree == 0) begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            fma_c_q     <= coef_s[first_idx_s];
                            fma_valid_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (fma_ready_i) begin
                        fma_valid_q     <= 1'b0;
                        fma_rsp_ready_q <= 1'b1;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fma_rsp_valid_i) begin
                        acc_q           <= fma_rsp_i;
                        fma_rsp_ready_q <= 1'b0;
                        if (k_q == KW'(0)) begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            k_q         <= k_q - KW'(1);
                            fma_c_q     <= coef_s[next_idx_s];
                            fma_valid_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    in_ready_q      <= 1'b1;
                    fma_valid_q     <= 1'b0;
                    fma_rsp_ready_q <= 1'b0;
                    out_valid_q     <= 1'b0;
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o      = in_ready_q;
    assign fma_valid_o     = fma_valid_q;
    assign fma_a_o         = acc_q;
    assign fma_b_o         = x_q;
    assign fma_c_o         = fma_c_q;
    assign fma_rsp_ready_o = fma_rsp_ready_q;
    assign out_valid_o     = out_valid_q;
    assign out_y_o         = acc_q;
    assign out_tag_o       = tag_q;
    assign out_eps_o       = eps_q;
    assign busy_o          = busy_q;

endmodule
